liteic_rr_arbiter: RTL and testbench
====================================

Name: liteic_rr_arbiter

Overview:
Round-robin arbiter sharing one interconnect slave port between N masters of the lite interconnect. Registers a one-hot grant and its binary index, holds the grant until the granted master's transaction completes, then rotates priority. Sits in front of the slave-side mux; the mux select is gnt_idx_o.

Parameters:
N_MASTERS, 4, number of requesters (≥2, need not be a power of 2)
IDX_W, $clog2(N_MASTERS), width of binary grant index
TIMEOUT_CYCLES, 256, max grant hold cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_i  input  N_MASTERS  per-master request, level
done_i  input  1  single-cycle pulse: granted transaction complete
gnt_o  output  N_MASTERS  registered one-hot grant
gnt_idx_o  output  IDX_W  binary index of granted master
gnt_valid_o  output  1  high while any grant is active
timeout_o  output  1  one-cycle pulse on forced release

Behaviour:
- One clock; reset is asynchronous and active-high. During/after reset: gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, priority pointer ptr=0, state IDLE.
- State register {IDLE, GRANT}; ptr is IDX_W bits, names the highest-priority master.
- Pick: winner = first set bit of req_i scanning ptr, ptr+1, ..., N_MASTERS-1, 0, ..., ptr-1. Pure combinational.
- IDLE: if |req_i, register winner into gnt_o/gnt_idx_o, gnt_valid_o=1, go GRANT. Latency: request-to-grant = 1 cycle. No request: stay IDLE, outputs 0.
- GRANT: gnt_* frozen regardless of req_i changes. Withdrawing req_i while granted is a protocol violation; grant still held until done_i; simulation-only assertion flags it.
- done_i in GRANT: ptr <= (gnt_idx_o+1) wrapping N_MASTERS-1→0 (no power-of-2 assumption). Same edge: re-pick with new ptr over current req_i masked by ~gnt_o; if nonzero, back-to-back grant to new winner (stay GRANT, no idle cycle); else clear gnt_*, go IDLE. Only master requesting again → returns to IDLE for one cycle, then re-granted.
- done_i in IDLE: ignored.
- Fairness: with all requests held, every master granted once in any N_MASTERS consecutive grants.
- gnt_idx_o always equals encoding of gnt_o; 0 when gnt_o=0.
- Reset mid-grant: immediate clear of all outputs, ptr=0.

Optional Feature:
LITEIC_ARB_TIMEOUT_EN
- Defined: hold counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on each new grant, increments each GRANT cycle; when it reaches TIMEOUT_CYCLES-1 with no done_i, release exactly as for done_i (ptr advance, re-pick) and pulse timeout_o for one cycle. done_i in the same cycle wins; no timeout_o.
- Undefined: no counter; timeout_o tied 0; grant held indefinitely.

Decomposition:
- Package liteic_arb_pkg: state enum arb_state_e {ARB_IDLE, ARB_GRANT}; function for wrapped increment of the index.
- Sub-module liteic_arb_pick: combinational rotate-by-ptr, first-one select, rotate back; outputs one-hot and binary index. Top holds FSM, ptr, optional counter.

Test Plan:
- Reset: assert rst with req_i=4'b1111 → all outputs 0; release → next edge gnt_o=0001, gnt_idx_o=0, gnt_valid_o=1.
- Skip and hand-over: req_i=0101, ptr=0 → gnt_o=0001; done_i pulse → next cycle gnt_o=0100, idx=2, no idle gap.
- Fairness: req_i=1111 constant, done_i every 3rd cycle → grant idx sequence 0,1,2,3,0,1 (N=4 and N=3 builds: 0,1,2,0).
- Wrap: grant idx 3, done_i, req_i=0011 → next grant idx 0; done_i in IDLE and req drop during GRANT → no state change, grant held.
- Reset mid-grant: rst pulse while gnt_o=0100 → outputs 0 asynchronously; after release, req_i=0100 → idx 2 (ptr back to 0).
- Timeout (TIMEOUT_CYCLES=8): macro on, no done_i → grant released after 8 cycles, timeout_o one-cycle pulse, next master granted; macro off → grant held 100 cycles, timeout_o stays 0.

Source files
------------

// File: rtl/liteic_arb_pkg.sv
//============================================================================
// Module      : liteic_arb_pkg
// Description : Shared types and helpers for the lite interconnect
//               round-robin arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package liteic_arb_pkg;

    // Arbiter control state: waiting for a request, or holding a grant.
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Next master index after idx, wrapping n-1 -> 0 for any n (not only 2^k).
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage : liteic_arb_pkg

`default_nettype wire

// File: rtl/liteic_arb_pick.sv
//============================================================================
// Module      : liteic_arb_pick
// Description : Combinational round-robin pick. Rotates the request vector
//               so the priority pointer lands on bit 0, selects the first
//               set bit, then maps the position back to a master index.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module liteic_arb_pick #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N_MASTERS);

    logic [2*N_MASTERS-1:0] w_dbl;
    logic [N_MASTERS-1:0]   w_rot;
    logic [IDX_W-1:0]       w_sel;
    logic [IDX_W:0]         w_sum;

    // Doubling the vector turns a rotate-right by ptr into a plain shift.
    assign w_dbl = {req, req};
    assign w_rot = N_MASTERS'(w_dbl >> ptr);
    assign any   = |req;

    // First set bit of the rotated vector (lowest position wins).
    always_comb begin
        w_sel = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end

    // Rotate back: position + ptr, modulo N_MASTERS without a divider.
    assign w_sum = {1'b0, w_sel} + {1'b0, ptr};
    assign idx   = !any          ? '0 :
                   (w_sum >= c_n) ? IDX_W'(w_sum - c_n) : IDX_W'(w_sum);

    // One-hot form of the chosen index.
    always_comb begin
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule : liteic_arb_pick

`default_nettype wire

// File: rtl/liteic_rr_arbiter.sv
//============================================================================
// Module      : liteic_rr_arbiter
// Description : Round-robin arbiter for one lite interconnect slave port.
//               Registers a one-hot grant plus its index, holds it until
//               done_i, then rotates priority past the finished master.
//               Optional macro LITEIC_ARB_TIMEOUT_EN adds a hold-time limit
//               that force-releases the grant and pulses timeout_o.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module liteic_rr_arbiter
    import liteic_arb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int IDX_W          = $clog2(N_MASTERS),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req_i,
    input  logic                 done_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 gnt_valid_o,
    output logic                 timeout_o
);

    arb_state_e           r_state, w_state_nxt;
    logic [N_MASTERS-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic                 w_new_grant;
    logic                 w_expire;

    logic [N_MASTERS-1:0] w_pick_gnt, w_rep_gnt;
    logic [IDX_W-1:0]     w_pick_idx, w_rep_idx, w_ptr_adv;
    logic                 w_pick_any, w_rep_any;

    // Pointer after the current owner finishes: one past the granted master.
    assign w_ptr_adv = IDX_W'(wrap_inc(int'(r_idx), N_MASTERS));

    // Fresh pick from IDLE using the stored pointer.
    liteic_arb_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req (req_i),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Hand-over pick on release: advanced pointer, finishing master masked.
    liteic_arb_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_repick (
        .req (req_i & ~r_gnt),
        .ptr (w_ptr_adv),
        .gnt (w_rep_gnt),
        .idx (w_rep_idx),
        .any (w_rep_any)
    );

`ifdef LITEIC_ARB_TIMEOUT_EN
    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign w_expire = (r_state == ARB_GRANT) && (r_cnt == c_cnt_last);

    // Hold-time counter: restarts on every new grant, counts GRANT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_new_grant) begin
            r_cnt <= '0;
        end else if (r_state == ARB_GRANT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        w_new_grant   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt   = w_pick_gnt;
                    w_idx_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ARB_GRANT;
                    w_new_grant = 1'b1;
                end
            end
            ARB_GRANT: begin
                // done_i takes precedence over a simultaneous expiry.
                if (done_i || w_expire) begin
                    w_ptr_nxt     = w_ptr_adv;
                    w_timeout_nxt = w_expire && !done_i;
                    if (w_rep_any) begin
                        w_gnt_nxt   = w_rep_gnt;
                        w_idx_nxt   = w_rep_idx;
                        w_new_grant = 1'b1;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_idx;
    assign gnt_valid_o = r_valid;
    assign timeout_o   = r_timeout;

`ifndef SYNTHESIS
    // Granted master must keep requesting until its transaction completes.
    always @(posedge clk) begin
        if (!rst) begin
            assert (TIMEOUT_CYCLES >= 2 && N_MASTERS >= 2)
                else $error("liteic_rr_arbiter: illegal parameters");
            assert (!(r_state == ARB_GRANT && !done_i && !req_i[r_idx]))
                else $error("liteic_rr_arbiter: req withdrawn while granted");
        end
    end
`endif

endmodule : liteic_rr_arbiter

`default_nettype wire

// File: tb/tb_liteic_rr_arbiter.sv
//============================================================================
// Module      : tb_liteic_rr_arbiter
// Description : Self-checking bench for liteic_rr_arbiter (N=4, timeout 8)
//               against an index-level round-robin reference model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_liteic_rr_arbiter;

    localparam int N  = 4;
    localparam int T  = 8;
`ifdef LITEIC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_i = '0;
    logic         done_i = 1'b0;
    logic [N-1:0] gnt_o;
    logic [1:0]   gnt_idx_o;
    logic         gnt_valid_o;
    logic         timeout_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: who holds the grant and who has priority.
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_timeout;

    liteic_rr_arbiter #(
        .N_MASTERS      (N),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = m_valid ? 4'(1 << m_idx) : 4'b0;
        return {g, m_valid ? 2'(m_idx) : 2'b0, m_valid, m_timeout};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_timeout = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        bit expire;
        int w;
        m_timeout = 0;
        if (!m_valid) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1; m_idx = w; m_cnt = 0;
            end
        end else begin
            expire = TO_EN && (m_cnt == T - 1) && !d;
            if (d || expire) begin
                m_ptr = (m_idx + 1) % N;
                m_timeout = expire;
                w = pick(r & ~(N'(1) << m_idx), m_ptr);
                if (w >= 0) begin
                    m_idx = w; m_cnt = 0;
                end else begin
                    m_valid = 0; m_idx = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic cycle(input logic [N-1:0] r, input logic d);
        req_i = r;
        done_i = d;
        model_step(r, d);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req_i = '0; done_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = 4'b1111; done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== 8'b0) begin
            errors++;
            $display("FAIL reset_hold got=%b expected=%b", {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, 8'b0);
        end
        rst = 1'b0;
        model_reset();
        cycle(4'b1111, 1'b0);
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o} !== {4'b0001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_grant got gnt=%b idx=%0d v=%b expected gnt=0001 idx=0 v=1", gnt_o, gnt_idx_o, gnt_valid_o);
        end
    endtask

    task automatic test_handover();
        apply_reset();
        cycle(4'b0101, 1'b0);
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o} !== {4'b0001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL handover_first got gnt=%b idx=%0d expected gnt=0001 idx=0", gnt_o, gnt_idx_o);
        end
        cycle(4'b0101, 1'b1);
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o} !== {4'b0100, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL handover_b2b got gnt=%b idx=%0d v=%b expected gnt=0100 idx=2 v=1", gnt_o, gnt_idx_o, gnt_valid_o);
        end
    endtask

    task automatic test_fairness();
        int seq[$];
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        bit prev_done;
        apply_reset();
        prev_done = 1'b0;
        for (int c = 0; c < 18; c++) begin
            cycle(4'b1111, (c % 3) == 2);
            checks++;
            if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL fairness_cyc%0d got=%b expected=%b", c, {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, exp_vec());
            end
            if (gnt_valid_o && (c == 0 || prev_done)) seq.push_back(int'(gnt_idx_o));
            prev_done = done_i;
        end
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL fairness_count got=%0d expected=6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seq[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL fairness_seq[%0d] got=%0d expected=%0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] pat [7] = '{4'b1000, 4'b0011, 4'b0001, 4'b0000, 4'b0010, 4'b1110, 4'b1110};
        logic         dn  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int s = 0; s < 7; s++) begin
            cycle(pat[s], dn[s]);
            checks++;
            if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_step%0d got=%b expected=%b", s, {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, exp_vec());
            end
        end
        checks++;
        if ({gnt_o, gnt_idx_o} !== {4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL wrap_hold got gnt=%b idx=%0d expected gnt=0010 idx=1", gnt_o, gnt_idx_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cycle(4'b0101, 1'b0);
        cycle(4'b0101, 1'b1);
        checks++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre got gnt=%b expected gnt=0100", gnt_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== 8'b0) begin
            errors++;
            $display("FAIL midrst_async got=%b expected=%b", {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, 8'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(4'b0011, 1'b0);
        checks++;
        if ({gnt_o, gnt_idx_o} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL midrst_ptr got gnt=%b idx=%0d expected gnt=0001 idx=0", gnt_o, gnt_idx_o);
        end
        cycle(4'b0100, 1'b1);
        checks++;
        if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== exp_vec() || gnt_idx_o !== 2'd2) begin
            errors++;
            $display("FAIL midrst_idx2 got=%b expected=%b", {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, exp_vec());
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first = -1;
        apply_reset();
        for (int c = 1; c <= 100; c++) begin
            cycle(4'b0011, 1'b0);
            checks++;
            if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_cyc%0d got=%b expected=%b", c, {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, exp_vec());
            end
            if (timeout_o === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (TO_EN ? (pulses != 12 || first != 9) : (pulses != 0 || gnt_o !== 4'b0001)) begin
            errors++;
            $display("FAIL timeout_summary got pulses=%0d first=%0d gnt=%b expected pulses=%0d first=%0d",
                     pulses, first, gnt_o, TO_EN ? 12 : 0, TO_EN ? 9 : -1);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         d;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            r = N'($urandom_range(0, 15));
            d = ($urandom_range(0, 3) == 0);
            if (m_valid && !d) r[m_idx] = 1'b1;
            cycle(r, d);
            checks++;
            if ({gnt_o, gnt_idx_o, gnt_valid_o, timeout_o} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cyc%0d req=%b done=%b got=%b expected=%b", c, r, d,
                         {gnt_o, gnt_idx_o, gnt_valid_o, timeout_o}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_handover();
        test_fairness();
        test_wrap();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_liteic_rr_arbiter

`default_nettype wire
